// File: rtl/repsub_divider_8bit.sv
// rtl/repsub_divider_8bit.sv - repeated-subtraction quotient/remainder unit with start/done handshake
// Define SIGNED_DIV_EN for two's-complement operands (truncating division on magnitudes).
module repsub_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div0
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic             div0_q;

  logic             divisor_zero;
  logic             can_sub;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] quo_inc;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  assign divisor_zero = (i_divisor == '0);

  // The compare guards the subtractor, so rem - dvs never underflows.
  assign can_sub  = (rem >= dvs);
  assign rem_diff = rem - dvs;
  assign quo_inc  = quo + ONE;

`ifdef SIGNED_DIV_EN
  logic sign_q;
  logic sign_r;

  // The most negative value's magnitude fits as an unsigned WIDTH-bit number.
  assign dividend_mag = i_dividend[WIDTH-1] ? (~i_dividend + ONE) : i_dividend;
  assign divisor_mag  = i_divisor[WIDTH-1]  ? (~i_divisor + ONE)  : i_divisor;
  assign quo_final    = sign_q ? (~quo + ONE) : quo;
  assign rem_final    = sign_r ? (~rem + ONE) : rem;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (state == S_IDLE && i_start) begin
      sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
      sign_r <= i_dividend[WIDTH-1];
    end
  end
`else
  assign dividend_mag = i_dividend;
  assign divisor_mag  = i_divisor;
  assign quo_final    = quo;
  assign rem_final    = rem;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      rem    <= '0;
      dvs    <= '0;
      quo    <= '0;
      div0_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            dvs <= divisor_mag;
            if (divisor_zero) begin
              // Divide-by-zero skips SUB and reports the raw dividend.
              quo    <= '1;
              rem    <= i_dividend;
              div0_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              quo    <= '0;
              rem    <= dividend_mag;
              div0_q <= 1'b0;
              state  <= S_SUB;
            end
          end
        end
        S_SUB: begin
          if (can_sub) begin
            rem <= rem_diff;
            quo <= quo_inc;
          end else begin
            rem   <= rem_final;
            quo   <= quo_final;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (state == S_SUB);
  assign o_done      = (state == S_DONE);
  assign o_quotient  = quo;
  assign o_remainder = rem;
  assign o_div0      = div0_q;

endmodule

// File: tb/tb_repsub_divider_8bit.sv
// tb/tb_repsub_divider_8bit.sv - self-checking bench for repsub_divider_8bit
module tb_repsub_divider_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       busy;
  logic       done;
  logic       div0;
  logic [7:0] quotient;
  logic [7:0] remainder;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  repsub_divider_8bit #(.WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_busy      (busy),
    .o_done      (done),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_div0      (div0)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        z;
    logic [15:0] lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values; latency = |Q| + 2, or 1 on divide-by-zero.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic z, output int lat);
    int qq;
    int rr;
`ifdef SIGNED_DIV_EN
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
`endif
    if (b == 8'd0) begin
      q = 8'hFF; r = a; z = 1'b1; lat = 1;
    end else begin
`ifdef SIGNED_DIV_EN
      qq = sa / sb;
      rr = sa % sb;
`else
      qq = int'(a) / int'(b);
      rr = int'(a) % int'(b);
`endif
      q = qq[7:0];
      r = rr[7:0];
      z = 1'b0;
      lat = ((qq < 0) ? -qq : qq) + 2;
    end
  endfunction

  task automatic apply_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] q_e, input logic [7:0] r_e,
                             input logic z_e, input int lat_e);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, " busy"}, 32'(busy), 32'(!z_e));
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(lat_e));
    check({tag, " quotient"}, 32'(quotient), 32'(q_e));
    check({tag, " remainder"}, 32'(remainder), 32'(r_e));
    check({tag, " div0"}, 32'(div0), 32'(z_e));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] q_e;
    logic [7:0] r_e;
    logic       z_e;
    logic [7:0] a;
    logic [7:0] b;
    int         lat_e;
    int         lat;
    bit         seen;

`ifdef SIGNED_DIV_EN
    vecs[0] = '{8'hF9, 8'd2,  8'hFD, 8'hFF, 1'b0, 16'd5};
    vecs[1] = '{8'd7,  8'hFE, 8'hFD, 8'd1,  1'b0, 16'd5};
    vecs[2] = '{8'h80, 8'hFF, 8'h80, 8'd0,  1'b0, 16'd130};
    vecs[3] = '{8'd37, 8'd0,  8'hFF, 8'd37, 1'b1, 16'd1};
    vecs[4] = '{8'd10, 8'd3,  8'd3,  8'd1,  1'b0, 16'd5};
    vecs[5] = '{8'd9,  8'd9,  8'd1,  8'd0,  1'b0, 16'd3};
`else
    vecs[0] = '{8'd5,  8'd9,  8'd0,  8'd5,  1'b0, 16'd2};
    vecs[1] = '{8'd9,  8'd9,  8'd1,  8'd0,  1'b0, 16'd3};
    vecs[2] = '{8'd0,  8'd4,  8'd0,  8'd0,  1'b0, 16'd2};
    vecs[3] = '{8'd37, 8'd0,  8'hFF, 8'd37, 1'b1, 16'd1};
    vecs[4] = '{8'd10, 8'd3,  8'd3,  8'd1,  1'b0, 16'd5};
    vecs[5] = '{8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 16'd17};
`endif

    #2 rst = 1'b1;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div0", 32'(div0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 100/7 then results must hold after the done pulse
    apply_check("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 16);
    repeat (3) @(negedge clk);
    check("hold quotient", 32'(quotient), 32'd14);
    check("hold remainder", 32'(remainder), 32'd2);
    check("hold done", 32'(done), 32'd0);

    for (int i = 0; i < 6; i++)
      apply_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                  vecs[i].z, int'(vecs[i].lat));

    // Reset mid-division
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (49) @(negedge clk);
    check("midrst busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst quotient", 32'(quotient), 32'd0);
    check("midrst remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_check("after_rst 9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 5);

    // Start held high: ignored while busy, relaunches in the first IDLE cycle
    model(8'd255, 8'd1, q_e, r_e, z_e, lat_e);
    @(negedge clk);
    start = 1'b1; dividend = 8'd255; divisor = 8'd1;
    @(posedge clk);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    check("held done_seen", 32'(seen), 32'd1);
    check("held latency", 32'(lat), 32'(lat_e));
    check("held quotient", 32'(quotient), 32'(q_e));
    check("held remainder", 32'(remainder), 32'(r_e));
    @(negedge clk);
    check("held idle_gap busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("held relaunch busy", 32'(busy), 32'(!z_e));
    start = 1'b0;
    lat = 0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("held relaunch done", 32'(done), 32'd1);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      model(a, b, q_e, r_e, z_e, lat_e);
      apply_check($sformatf("rand%0d %0d/%0d", i, a, b), a, b, q_e, r_e, z_e, lat_e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
